uart_tx: RTL
============

// Module: uart_tx
// PURPOSE
//   UART transmitter. It is the transmit-side counterpart to the start-bit edge detection on the RX path.
//   - Accepts one byte per valid/ready handshake.
//   - Serialises the byte as 8N1 (optional even parity), LSB first, on tx_o.
//   - Sits between the host-side byte source (FIFO or controller) and the FPGA TX pin.
// PARAMETERS
//   CLK_FREQ   50_000_000  system clock frequency, Hz
//   BAUD_RATE  115_200     line bit rate, bit/s
//   DATA_BITS  8           payload bits per frame (5..8)
//   Derived (localparam): CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division); CLKS_PER_BIT must be >= 2.
// PORTS
//   clk_i       in   1          system clock; all logic is on the rising edge
//   rst_n_i     in   1          reset, synchronous, active-low
//   tx_data_i   in   DATA_BITS  byte to send; sampled at handshake
//   tx_valid_i  in   1          source has a byte to send
//   tx_ready_o  out  1          block can accept a byte (high in IDLE only)
//   tx_busy_o   out  1          a frame is in progress
//   tx_o        out  1          serial line; idle level is high
// BEHAVIOUR
//   - Reset (rst_n_i=0 at a clk_i edge): tx_o=1, tx_ready_o=1, tx_busy_o=0, state=IDLE, all counters cleared.
//     * Reset mid-frame abandons the frame; tx_o is 1 after that edge.
//   - Handshake: a transfer occurs on an edge where tx_valid_i & tx_ready_o.
//     * tx_data_i is latched into the shift register.
//     * On the next edge: tx_ready_o=0, tx_busy_o=1, tx_o=0 (start bit).
//   - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//     * Each non-IDLE state drives tx_o for exactly CLKS_PER_BIT cycles, counted by the baud counter
//       (width $clog2(CLKS_PER_BIT)).
//     * DATA sends DATA_BITS bits, LSB first, using a shift register and a bit counter
//       (width $clog2(DATA_BITS)); tx_o is registered directly from the FSM/shift register, with no glitch path.
//     * STOP holds tx_o=1 for one bit time (CLKS_PER_BIT cycles).
//       - On its last cycle the FSM goes to IDLE; tx_ready_o=1 and tx_busy_o=0 from the next edge.
//   - Latency: handshake edge to start-bit edge is 1 cycle.
//     * Frame length is (2+DATA_BITS[+1])*CLKS_PER_BIT cycles.
//     * With tx_valid_i held high, the gap between frames is 1 clock of idle-high (the IDLE accept cycle).
//   - tx_valid_i and tx_data_i are ignored while tx_ready_o=0.
//     * There is no queuing: the source must hold valid until the handshake.
// CONFIGURATION
//   - Macro UART_TX_PARITY_EN
//     * Defined: PARITY state is inserted after DATA.
//       - tx_o = XOR of the latched data bits (even parity), held for CLKS_PER_BIT cycles.
//       - Frame is DATA_BITS+3 bit times.
//     * Undefined: no PARITY state and no parity logic; DATA goes straight to STOP (8N1).
// STRUCTURE
//   - Package uart_pkg:
//     * typedef tx_state_t {IDLE, START, DATA, PARITY, STOP}
//     * function clks_per_bit(CLK_FREQ, BAUD_RATE)
//     * constant UART_IDLE_LEVEL = 1'b1
//     * All of this is shared with the RX path.
//   - Sub-module uart_baud_cnt: bit-time counter with a load/clear input and a one-cycle bit_done pulse
//     at count CLKS_PER_BIT-1. It is reusable by RX.
// TESTING  (sim params: CLK_FREQ=1_000_000, BAUD_RATE=100_000 -> CLKS_PER_BIT=10)
//   1. Reset held 3 cycles, then released -> tx_o=1, tx_ready_o=1, tx_busy_o=0; tx_o stays 1 while valid=0.
//   2. Send 0x55 -> tx_o = 0,1,0,1,0,1,0,1,0,1.
//      - Each level lasts 10 cycles: start, then LSB first, then stop.
//      - tx_ready_o is low for 100 cycles.
//   3. 0xA5 then 0x3C with tx_valid_i held -> two correct frames; second start bit exactly 1 cycle after first stop ends.
//   4. During the 0x55 frame, drive tx_valid_i=1 with tx_data_i=0xFF -> no handshake; 0x55 frame unaltered;
//      0xFF sent only after tx_ready_o returns.
//   5. Reset asserted at cycle 5 of data bit 3 -> tx_o=1 and tx_ready_o=1 after that edge;
//      the next byte 0x81 then transmits cleanly.
//   6. With UART_TX_PARITY_EN: send 0x07 -> parity bit 1 after bit 7; frame 110 cycles.
//      Send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the TX and RX paths.
// Holds the FSM state type, the bit-time divider function and the line idle level.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam logic UART_IDLE_LEVEL = 1'b1;

   // Integer division; the caller must keep the result >= 2.
   function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and pulses bit_done_o on the last count.
// clear_i holds the count at zero so the first bit time starts cleanly after a release.
import uart_pkg::*;

module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clear_i,
   output logic bit_done_o
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clear_i || (cnt_q == LAST_CNT)) cnt_d = '0;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign bit_done_o = (cnt_q == LAST_CNT) && !clear_i;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, sent LSB first as 8N1.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and the stop bit.
import uart_pkg::*;

module uart_tx #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115_200,
   parameter int DATA_BITS = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [DATA_BITS-1:0] tx_data_i,
   input  logic                 tx_valid_i,
   output logic                 tx_ready_o,
   output logic                 tx_busy_o,
   output logic                 tx_o
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int BIT_W = $clog2(DATA_BITS);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

   tx_state_t            state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic                 tx_q, tx_d;
   logic                 bit_done;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   // Counter is held clear while idle so START always gets a full bit time.
   uart_baud_cnt #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_cnt (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .clear_i    (state_q == IDLE),
      .bit_done_o (bit_done)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      case (state_q)
         IDLE: begin
            tx_d = UART_IDLE_LEVEL;
            if (tx_valid_i) begin
               shift_d = tx_data_i;
`ifdef UART_TX_PARITY_EN
               parity_d = ^tx_data_i;
`endif
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (bit_done) begin
               tx_d      = shift_q[0];
               shift_d   = shift_q >> 1;
               bit_cnt_d = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (bit_done) begin
               if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = parity_q;
                  state_d = PARITY;
`else
                  tx_d    = UART_IDLE_LEVEL;
                  state_d = STOP;
`endif
               end else begin
                  tx_d      = shift_q[0];
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_done) begin
               tx_d    = UART_IDLE_LEVEL;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (bit_done) state_d = IDLE;
         end
         default: begin
            tx_d    = UART_IDLE_LEVEL;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         tx_q      <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign tx_o       = tx_q;
   assign tx_ready_o = (state_q == IDLE);
   assign tx_busy_o  = (state_q != IDLE);

endmodule
